// File: rtl/green_sequencer_if.sv
// Bus between the green sequencer and the green execute circuit.
//   master (sequencer): drives op_out, a_out, b_out, znc_out, we_out;
//                       receives a_res, b_res, znc_res, br_res.
//   slave  (execute circuit): the mirror image.
interface green_sequencer_if;
  logic [15:0] op_out;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [2:0]  znc_out;
  logic        we_out;
  logic [15:0] a_res;
  logic [15:0] b_res;
  logic [2:0]  znc_res;
  logic        br_res;

  modport master (
    output op_out, a_out, b_out, znc_out, we_out,
    input  a_res, b_res, znc_res, br_res
  );

  modport slave (
    input  op_out, a_out, b_out, znc_out, we_out,
    output a_res, b_res, znc_res, br_res
  );
endinterface

// File: rtl/green_sequencer.sv
// Instruction sequencer for the green execute circuit.
// Fetches 16-bit words from program memory, holds the A/B/ZNC architectural
// state, hands it to the execute circuit and latches the results back.
// Each retired instruction takes FETCH -> EXEC -> WB (3 cycles).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin execution from PC 0 (accepted in IDLE/HALTED only)
//   a_init, b_init  A/B values loaded on an accepted start
//   imem_addr/data  program memory address (= PC) and combinational read data
//   bus             execute-circuit bus (opcode, operands, write enable, results)
//   busy, halted    status; instr_count = retired instructions (saturating)
module green_sequencer #(
  parameter int          PC_W       = 8,
  parameter logic [3:0]  ST_CLASS   = 4'h3,
  parameter logic [3:0]  HALT_CLASS = 4'hF,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          a_init,
  input  logic [15:0]          b_init,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [15:0]          imem_data,
  green_sequencer_if.master    bus,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALTED
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir, a_q, b_q;
  logic [2:0]      znc_q;
  logic            br_q;
  logic [CNT_W-1:0] cnt;
  logic            is_halt, is_st, start_ok, we;

  assign is_halt  = (ir[15:12] == HALT_CLASS);
  // HALT takes priority should the two class parameters ever coincide
  assign is_st    = (ir[15:12] == ST_CLASS) && !is_halt;
  assign start_ok = start && (state == S_IDLE || state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (is_halt) state_nxt = S_HALTED;
        else begin
          state_nxt = S_WB;
          we        = is_st;
        end
      end
      S_WB: begin
        busy      = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      znc_q <= '0;
      br_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: if (start_ok) begin
          a_q   <= a_init;
          b_q   <= b_init;
          znc_q <= '0;
          pc    <= '0;
          cnt   <= '0;
        end
        S_FETCH: ir <= imem_data;
        // Results are taken at the end of EXEC while operands are still stable
        S_EXEC: if (!is_halt) begin
          a_q   <= bus.a_res;
          b_q   <= bus.b_res;
          znc_q <= bus.znc_res;
          br_q  <= bus.br_res;
        end
        S_WB: begin
          pc <= br_q ? ir[PC_W-1:0] : pc + 1'b1;  // wraps naturally
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = pc;
  assign instr_count = cnt;
  assign bus.op_out  = ir;
  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.znc_out = znc_q;
  assign bus.we_out  = we;

endmodule
